// File: rtl/four_bit_adder.sv
// Purpose : 4-bit unsigned ripple-carry adder with carry-in/carry-out, registered outputs.
// Latency : 1 cycle; operands sampled at rising clk edge N are visible on sum/co after edge N.
// Backpressure: none; a new operand pair is accepted every cycle, outputs hold between edges.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset; clears sum/co at the next rising edge
//   a, b  - unsigned operands
//   ci    - carry-in into stage 0
//   sum   - registered (a + b + ci) mod 2^WIDTH
//   co    - registered carry-out of the top stage
module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  // Carry chain: c[i] enters stage i, c[WIDTH] leaves the top stage.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p;      // per-stage propagate (a ^ b)
  logic [WIDTH-1:0] g;      // per-stage generate  (a & b)
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             co_d,  co_q;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign p[i]   = a[i] ^ b[i];
    assign g[i]   = a[i] & b[i];
    assign s[i]   = p[i] ^ c[i];
    // A stage carries out when it generates, or when it propagates an incoming carry.
    assign c[i+1] = g[i] | (c[i] & p[i]);
  end

  assign sum_d = s;
  assign co_d  = c[WIDTH];

  // Reset wins over whatever operands are present at the edge, so a result
  // in flight during reset is dropped rather than emerging afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
    end
  end

  assign sum = sum_q;
  assign co  = co_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// Bench for four_bit_adder: directed plan steps, an exhaustive 512-case sweep and
// random operands, each result checked one edge after its operands are applied
// against plain integer arithmetic, plus a hold check after inputs change.
module tb_four_bit_adder;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic [3:0] sum;
  logic       co;

  int checks = 0;
  int errors = 0;

  // Expected {co,sum} of the most recent edge, used to confirm outputs hold.
  logic [4:0] prev_exp;
  bit         prev_vld = 1'b0;

  four_bit_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .sum   (sum),
    .co    (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed co=%b sum=%h, expected co=%b sum=%h",
             tag, obs[4], obs[3:0], exp[4], exp[3:0]);
    end
  endtask

  // Drive one operand set at the falling edge, confirm the previous result
  // is still held, then check the new result just after the rising edge.
  task automatic apply(input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic tci, input logic trst, input string tag);
    logic [4:0] exp;
    int         total;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    ci    = tci;
    rst_n = trst;
    total = int'(ta) + int'(tb_v) + int'(tci);
    exp   = trst ? 5'(total) : 5'd0;
    #1;
    if (prev_vld) check({tag, "/hold"}, {co, sum}, prev_exp);
    @(posedge clk);
    #1;
    check(tag, {co, sum}, exp);
    prev_exp = exp;
    prev_vld = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 4'h0;
    b     = 4'h0;
    ci    = 1'b0;

    // Reset held for two edges with all-ones operands, then released.
    apply(4'hF, 4'hF, 1'b1, 1'b0, "reset0");
    apply(4'hF, 4'hF, 1'b1, 1'b0, "reset1");
    apply(4'hF, 4'hF, 1'b1, 1'b1, "reset_release");

    // Sweep b=k, a=k/2, with a one-cycle reset pulse mid-stream at k=8.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kb;
      logic [3:0] ka;
      kb = 4'(k);
      ka = 4'(k / 2);
      apply(ka, kb, 1'b0, (k == 8) ? 1'b0 : 1'b1, $sformatf("sweep_k%0d", k));
    end

    // Carry-in and full ripple directed cases.
    apply(4'h7, 4'h8, 1'b1, 1'b1, "carry_in1");
    apply(4'h7, 4'h8, 1'b0, 1'b1, "carry_in0");
    apply(4'hF, 4'h0, 1'b1, 1'b1, "full_ripple");
    apply(4'h0, 4'hF, 1'b1, 1'b1, "full_ripple_b");

    // Exhaustive over (a, b, ci), one per cycle.
    for (int n = 0; n < 512; n++) begin
      logic [8:0] v;
      v = 9'(n);
      apply(v[8:5], v[4:1], v[0], 1'b1, $sformatf("exh_a%h_b%h_c%0d", v[8:5], v[4:1], v[0]));
    end

    // Random operands, with occasional reset assertions.
    for (int r = 0; r < 200; r++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      logic       rr;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 19) != 0);
      apply(ra, rb, rc, rr, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
